// File: rtl/pwm_fade_ctrl_if.sv
// Fade controller bus: start/stop/loop_en control in, PWM duty and status out.
// Pure wiring, no latency.
// No backpressure: all signals are levels or single-cycle pulses.
interface pwm_fade_ctrl_if;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [7:0] duty;
  logic       pwm_rst;
  logic       busy;
  logic       done;
  logic [7:0] cycles;

  modport master (
    output start, stop, loop_en,
    input  duty, pwm_rst, busy, done, cycles
  );

  modport slave (
    input  start, stop, loop_en,
    output duty, pwm_rst, busy, done, cycles
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Breathing-LED fade sequencer: ramps a PWM duty 0->255->0 in STEP increments.
// Latency: one clk from start/stop to registered outputs; duty moves every TICK_DIV clks.
// No backpressure: start is ignored while busy; stop always wins and aborts to idle.
module pwm_fade_ctrl #(
  parameter int TICK_DIV   = 27000000,
  parameter int STEP       = 10,
  parameter int HOLD_TICKS = 2
) (
  input  logic          clk,
  input  logic          rst,
  pwm_fade_ctrl_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [HW-1:0] hold_q;
  logic [7:0]    duty_q;
  logic [7:0]    cycles_q;
  logic          pwm_rst_q;
  logic          busy_q;
  logic          done_q;

  logic          tick_d;
  logic          hold_last_d;
  logic [8:0]    up_sum_d;
  logic [7:0]    up_duty_d;
  logic [7:0]    dn_duty_d;

  // Step strobe and saturated next-duty values for both ramp directions.
  always_comb begin
    tick_d      = (tick_q == TW'(TICK_DIV - 1));
    hold_last_d = (hold_q == HW'(HOLD_TICKS - 1));
    up_sum_d    = {1'b0, duty_q} + 9'(STEP);
    up_duty_d   = up_sum_d[8] ? 8'hFF : up_sum_d[7:0];
    dn_duty_d   = (duty_q > 8'(STEP)) ? (duty_q - 8'(STEP)) : 8'h00;
  end

  // Fade FSM with all outputs registered; stop has priority over any step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      hold_q    <= '0;
      duty_q    <= 8'h00;
      cycles_q  <= 8'h00;
      pwm_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pwm_rst_q <= 1'b0;
      done_q    <= 1'b0;
      if (state_q == S_IDLE) begin
        tick_q <= '0;
        hold_q <= '0;
        if (bus.start && !bus.stop) begin
          state_q <= S_UP;
          busy_q  <= 1'b1;
        end
      end else if (bus.stop) begin
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        tick_q    <= '0;
        hold_q    <= '0;
        duty_q    <= 8'h00;
        pwm_rst_q <= (duty_q != 8'h00);
      end else begin
        tick_q <= tick_d ? '0 : tick_q + 1'b1;
        if (tick_d) begin
          case (state_q)
            S_UP: begin
              duty_q    <= up_duty_d;
              pwm_rst_q <= (up_duty_d != duty_q);
              if (up_duty_d == 8'hFF) begin
                state_q <= S_HOLD_HI;
                hold_q  <= '0;
              end
            end
            S_HOLD_HI, S_HOLD_LO: begin
              if (hold_last_d) begin
                hold_q  <= '0;
                state_q <= (state_q == S_HOLD_HI) ? S_DOWN : S_UP;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
            S_DOWN: begin
              duty_q    <= dn_duty_d;
              pwm_rst_q <= (dn_duty_d != duty_q);
              if (dn_duty_d == 8'h00) begin
                cycles_q <= cycles_q + 8'd1;
                if (bus.loop_en) begin
                  state_q <= S_HOLD_LO;
                  hold_q  <= '0;
                end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
            default: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.duty    = duty_q;
  assign bus.pwm_rst = pwm_rst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cycles  = cycles_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: vector table, corner sequences, randomized run vs reference model.
// Outputs sampled 1 time unit after each rising edge.
// No backpressure on the DUT; inputs change only just after a rising edge.
module tb_pwm_fade_ctrl;

  localparam int M_TD   = 4;
  localparam int M_STEP = 64;
  localparam int M_HOLD = 2;

  logic clk = 1'b0;
  logic rst;

  pwm_fade_ctrl_if b1();
  pwm_fade_ctrl_if b2();

  pwm_fade_ctrl #(.TICK_DIV(M_TD), .STEP(M_STEP), .HOLD_TICKS(M_HOLD)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  pwm_fade_ctrl #(.TICK_DIV(4), .STEP(255), .HOLD_TICKS(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 rising, 2 hold high, 3 falling, 4 hold low.
  int m_phase, m_age, m_holds, m_duty, m_pwm, m_done, m_cycles;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_holds = 0; m_duty = 0;
    m_pwm = 0; m_done = 0; m_cycles = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit lp);
    int nd;
    bit tick;
    m_pwm  = 0;
    m_done = 0;
    if (m_phase == 0) begin
      if (st && !sp) begin
        m_phase = 1;
        m_age   = 0;
      end
    end else if (sp) begin
      m_pwm   = (m_duty != 0);
      m_duty  = 0;
      m_phase = 0;
      m_age   = 0;
      m_holds = 0;
    end else begin
      tick  = ((m_age % M_TD) == M_TD - 1);
      m_age = m_age + 1;
      if (tick) begin
        if (m_phase == 1) begin
          nd     = (m_duty + M_STEP > 255) ? 255 : m_duty + M_STEP;
          m_pwm  = (nd != m_duty);
          m_duty = nd;
          if (nd == 255) begin m_phase = 2; m_holds = 0; end
        end else if (m_phase == 2 || m_phase == 4) begin
          m_holds = m_holds + 1;
          if (m_holds == M_HOLD) begin
            m_phase = (m_phase == 2) ? 3 : 1;
            m_holds = 0;
          end
        end else begin
          nd     = (m_duty < M_STEP) ? 0 : m_duty - M_STEP;
          m_pwm  = (nd != m_duty);
          m_duty = nd;
          if (nd == 0) begin
            m_cycles = (m_cycles + 1) % 256;
            if (lp) begin m_phase = 4; m_holds = 0; end
            else begin m_phase = 0; m_done = 1; end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(b1.start, b1.stop, b1.loop_en);
    #1;
    chk("model_duty",    int'(b1.duty),    m_duty);
    chk("model_pwm_rst", int'(b1.pwm_rst), m_pwm);
    chk("model_busy",    int'(b1.busy),    int'(m_phase != 0));
    chk("model_done",    int'(b1.done),    m_done);
    chk("model_cycles",  int'(b1.cycles),  m_cycles);
  endtask

  typedef struct {
    logic start;
    logic stop;
    logic loop_en;
    int   n;
    int   duty;
    int   pwm;
    int   busy;
    int   done;
    int   cyc;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // start/stop/loop, cycles to run, then duty/pwm_rst/busy/done/cycles expected
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1,   0, 0, 1, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4,  64, 1, 1, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4, 128, 1, 1, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4, 192, 1, 1, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4, 255, 1, 1, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4, 255, 0, 1, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4, 255, 0, 1, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4, 191, 1, 1, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1, 191, 0, 1, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3, 127, 1, 1, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4,  63, 1, 1, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4,   0, 1, 0, 1, 1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1,   0, 0, 0, 0, 1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1,   0, 0, 1, 0, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8, 128, 1, 1, 0, 1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1,   0, 1, 0, 0, 1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1,   0, 0, 0, 0, 1};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 3,   0, 0, 0, 0, 1};

    rst = 1'b1;
    b1.start = 1'b0; b1.stop = 1'b0; b1.loop_en = 1'b0;
    b2.start = 1'b0; b2.stop = 1'b0; b2.loop_en = 1'b0;
    model_reset();

    // Reset acts before any clock edge.
    #1;
    chk("rst_duty",   int'(b1.duty),    0);
    chk("rst_busy",   int'(b1.busy),    0);
    chk("rst_pwm",    int'(b1.pwm_rst), 0);
    chk("rst_done",   int'(b1.done),    0);
    chk("rst_cycles", int'(b1.cycles),  0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single fade, stop mid-ramp, simultaneous start+stop.
    for (int i = 0; i < 18; i++) begin
      b1.start   = vecs[i].start;
      b1.stop    = vecs[i].stop;
      b1.loop_en = vecs[i].loop_en;
      repeat (vecs[i].n) cycle();
      chk($sformatf("vec%0d_duty", i),    int'(b1.duty),    vecs[i].duty);
      chk($sformatf("vec%0d_pwm_rst", i), int'(b1.pwm_rst), vecs[i].pwm);
      chk($sformatf("vec%0d_busy", i),    int'(b1.busy),    vecs[i].busy);
      chk($sformatf("vec%0d_done", i),    int'(b1.done),    vecs[i].done);
      chk($sformatf("vec%0d_cycles", i),  int'(b1.cycles),  vecs[i].cyc);
    end
    b1.start = 1'b0; b1.stop = 1'b0;

    // Continuous breathing until the cycle counter wraps.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    b1.loop_en = 1'b1;
    b1.start   = 1'b1;
    cycle();
    b1.start = 1'b0;
    repeat (12279) cycle();
    chk("loop_pre_wrap_cycles", int'(b1.cycles), 255);
    chk("loop_pre_wrap_duty",   int'(b1.duty),   63);
    cycle();
    chk("loop_wrap_cycles", int'(b1.cycles), 0);
    chk("loop_wrap_duty",   int'(b1.duty),   0);
    chk("loop_wrap_busy",   int'(b1.busy),   1);
    chk("loop_wrap_done",   int'(b1.done),   0);
    b1.stop = 1'b1;
    cycle();
    b1.stop = 1'b0;
    b1.loop_en = 1'b0;

    // Asynchronous reset while ramping down, between clock edges.
    b1.start = 1'b1;
    cycle();
    b1.start = 1'b0;
    repeat (30) cycle();
    chk("pre_arst_duty", int'(b1.duty), 191);
    #2 rst = 1'b1;
    #1;
    chk("arst_duty",   int'(b1.duty),   0);
    chk("arst_busy",   int'(b1.busy),   0);
    chk("arst_cycles", int'(b1.cycles), 0);
    chk("arst_pwm",    int'(b1.pwm_rst), 0);
    cycle();
    rst = 1'b0;
    repeat (12) cycle();
    chk("post_arst_idle_busy", int'(b1.busy), 0);
    chk("post_arst_idle_duty", int'(b1.duty), 0);

    // Randomized control against the reference model.
    for (int i = 0; i < 3000; i++) begin
      b1.start   = ($urandom_range(0, 9) == 0);
      b1.stop    = ($urandom_range(0, 63) == 0);
      b1.loop_en = $urandom_range(0, 1);
      rst        = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;
    b1.start = 1'b0; b1.stop = 1'b0;
    cycle();

    // Full-range step: one tick each way.
    b2.start = 1'b1;
    cycle();
    b2.start = 1'b0;
    chk("s255_busy0", int'(b2.busy), 1);
    chk("s255_duty0", int'(b2.duty), 0);
    repeat (4) cycle();
    chk("s255_up_duty", int'(b2.duty),    255);
    chk("s255_up_pwm",  int'(b2.pwm_rst), 1);
    repeat (8) cycle();
    chk("s255_hold_duty", int'(b2.duty),    255);
    chk("s255_hold_pwm",  int'(b2.pwm_rst), 0);
    repeat (4) cycle();
    chk("s255_dn_duty",   int'(b2.duty),    0);
    chk("s255_dn_pwm",    int'(b2.pwm_rst), 1);
    chk("s255_dn_done",   int'(b2.done),    1);
    chk("s255_dn_busy",   int'(b2.busy),    0);
    chk("s255_dn_cycles", int'(b2.cycles),  1);
    cycle();
    chk("s255_done_pulse", int'(b2.done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
